// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed RV32 data memory for the MEM stage.
// Byte/half/word loads and stores with sign or zero extension on loads,
// a req/ready/done handshake and WAIT_CYCLES wait states before the access.
// Misaligned or illegal-size accesses raise err with done and leave memory untouched.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous active-low reset
//   req           access request, sampled while ready=1
//   MemWrite      1=store, 0=load (latched on accept)
//   addr          byte address (latched on accept)
//   data_in       store data (latched on accept)
//   u             1=zero-extend loads, 0=sign-extend
//   mem_inst_type 00=byte, 01=half, 10=word, 11=illegal
//   ready         idle, can accept a request
//   done          one-cycle completion pulse
//   err           misaligned/illegal flag, valid with done
//   data_out      load result, held until the next done
//
// state | meaning
// IDLE  | ready=1, waiting for req
// BUSY  | wait-state down-counter running; access when it reaches zero
// RESP  | done=1 for one cycle, result on data_out/err
module data_mem_ctrl #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1,
   parameter int CNT_W       = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       data_in,
   input  logic              u,
   input  logic [1:0]        mem_inst_type,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic [31:0]       data_out
);

   localparam int WORDS = 2**(ADDR_W-2);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

   state_t            state, state_nxt;
   logic              we_q, u_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [1:0]        size_q;
   logic [CNT_W-1:0]  cnt;

   logic [31:0]       mem [WORDS];

   logic              access, acc_err;
   logic [3:0]        byte_en;
   logic [31:0]       wr_word, rd_word, sel_word, ld_val;
   logic [ADDR_W-3:0] word_idx;
   logic [1:0]        lane;

   assign word_idx = addr_q[ADDR_W-1:2];
   assign lane     = addr_q[1:0];
   assign access   = (state == BUSY) && (cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = BUSY;
         BUSY:    if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = (state == IDLE);
      done  = (state == RESP);
   end

   // Lane enables and replicated store data; the replication lets the byte
   // loop below pick the right bits regardless of lane.
   always_comb begin
      acc_err = 1'b0;
      byte_en = 4'b0000;
      wr_word = wdata_q;
      case (size_q)
         2'b00: begin
            byte_en = 4'b0001 << lane;
            wr_word = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            acc_err = lane[0];
            byte_en = lane[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{wdata_q[15:0]}};
         end
         2'b10: begin
            acc_err = (lane != 2'b00);
            byte_en = 4'b1111;
         end
         default: acc_err = 1'b1;
      endcase
   end

   assign rd_word  = mem[word_idx];
   assign sel_word = rd_word >> {lane, 3'b000};

   always_comb begin
      ld_val = rd_word;
      case (size_q)
         2'b00:   ld_val = u_q ? {24'h0, sel_word[7:0]}
                               : {{24{sel_word[7]}}, sel_word[7:0]};
         2'b01:   ld_val = u_q ? {16'h0, sel_word[15:0]}
                               : {{16{sel_word[15]}}, sel_word[15:0]};
         default: ld_val = rd_word;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q     <= 1'b0;
         u_q      <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= 2'b00;
         cnt      <= '0;
         err      <= 1'b0;
         data_out <= '0;
      end else begin
         if (state == IDLE && req) begin
            we_q    <= MemWrite;
            u_q     <= u;
            addr_q  <= addr;
            wdata_q <= data_in;
            size_q  <= mem_inst_type;
            cnt     <= CNT_W'(WAIT_CYCLES);
         end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
         if (access) begin
            err      <= acc_err;
            data_out <= (acc_err || we_q) ? 32'h0 : ld_val;
         end else if (state == RESP) begin
            err <= 1'b0;
         end
      end
   end

   // No reset on the array; reset forces IDLE so a pending store never fires.
   always_ff @(posedge clk) begin
      if (access && we_q && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;
   localparam int AW = 10;
   localparam int W  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, req, mem_write, u, ready, done, err;
   logic [AW-1:0] addr;
   logic [31:0]   data_in, data_out;
   logic [1:0]    mtype;

   logic          rst_z, req_z, mem_write_z, u_z, ready_z, done_z, err_z;
   logic [AW-1:0] addr_z;
   logic [31:0]   data_in_z, data_out_z;
   logic [1:0]    mtype_z;

   data_mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req(req), .MemWrite(mem_write), .addr(addr),
      .data_in(data_in), .u(u), .mem_inst_type(mtype), .ready(ready),
      .done(done), .err(err), .data_out(data_out));

   data_mem_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(0), .CNT_W(4)) dut_z (
      .clk(clk), .rst(rst_z), .req(req_z), .MemWrite(mem_write_z), .addr(addr_z),
      .data_in(data_in_z), .u(u_z), .mem_inst_type(mtype_z), .ready(ready_z),
      .done(done_z), .err(err_z), .data_out(data_out_z));

   typedef struct {logic e; logic [31:0] d; int cyc;} exp_t;
   exp_t sb[$];
   byte unsigned ref_mem [0:(1<<AW)-1];
   int cyc = 0;
   int n_cmp = 0, n_bad = 0;
   logic mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model over a flat byte array: little-endian, size-checked.
   function automatic exp_t model(input logic we, input logic [AW-1:0] a,
                                  input logic [31:0] d, input logic uu, input logic [1:0] t);
      exp_t r;
      int n;
      logic [31:0] v;
      r.cyc = 0;
      r.d   = 32'h0;
      r.e   = (t == 2'b11) || (t == 2'b01 && a[0]) || (t == 2'b10 && a[1:0] != 2'b00);
      if (r.e) return r;
      n = (t == 2'b00) ? 1 : (t == 2'b01) ? 2 : 4;
      if (we) begin
         for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
         return r;
      end
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8*i));
      if (!uu && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uu && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      r.d = v;
      return r;
   endfunction

   function automatic logic [AW-1:0] rand_addr(input logic [1:0] t);
      logic [AW-1:0] a;
      a = AW'($urandom);
      if ($urandom_range(0, 3) != 0) begin
         if (t == 2'b01) a[0] = 1'b0;
         if (t == 2'b10) a[1:0] = 2'b00;
      end
      return a;
   endfunction

   task automatic rand_inputs();
      mem_write = 1'($urandom);
      mtype     = 2'($urandom);
      addr      = rand_addr(mtype);
      data_in   = $urandom;
      u         = 1'($urandom);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                        input logic uu, input logic [1:0] t);
      exp_t e;
      int g = 0;
      while (ready !== 1'b1 && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) begin
         check("ready_timeout", 32'(ready), 32'h1);
         return;
      end
      mem_write = we; addr = a; data_in = d; u = uu; mtype = t; req = 1'b1;
      e = model(we, a, d, uu, t);
      e.cyc = cyc + 2 + W;
      sb.push_back(e);
      @(negedge clk);
      req = 1'b0;
      check("ready_busy", 32'(ready), 32'h0);
      rand_inputs();
   endtask

   // req held high; inputs change every cycle and only the accepted ones count.
   task automatic burst(input int n);
      exp_t e;
      int issued = 0, g = 0, last = -1;
      rand_inputs();
      req = 1'b1;
      while (issued < n && g < 2000) begin
         if (ready === 1'b1) begin
            e = model(mem_write, addr, data_in, u, mtype);
            e.cyc = cyc + 2 + W;
            sb.push_back(e);
            if (last >= 0) check("burst_spacing", 32'(cyc - last), 32'(W + 3));
            last = cyc;
            issued++;
         end
         @(negedge clk);
         rand_inputs();
         g++;
      end
      req = 1'b0;
      if (issued < n) check("burst_timeout", 32'(issued), 32'(n));
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'h0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               check("spurious_done", 32'h1, 32'h0);
            end else begin
               e = sb.pop_front();
               check("err", 32'(err), 32'(e.e));
               check("data_out", data_out, e.d);
               check("latency", 32'(cyc), 32'(e.cyc));
            end
         end else if (err !== 1'b0) begin
            check("err_without_done", 32'(err), 32'h0);
         end
      end
   end

   task automatic op_z(input string nm, input logic we, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic uu, input logic [1:0] t,
                       input logic [31:0] exp_d, input logic exp_e);
      mem_write_z = we; addr_z = a; data_in_z = d; u_z = uu; mtype_z = t; req_z = 1'b1;
      @(negedge clk);
      req_z = 1'b0;
      check({nm, "_busy_ready"}, 32'(ready_z), 32'h0);
      check({nm, "_busy_done"}, 32'(done_z), 32'h0);
      @(negedge clk);
      check({nm, "_done"}, 32'(done_z), 32'h1);
      check({nm, "_data"}, data_out_z, exp_d);
      check({nm, "_err"}, 32'(err_z), 32'(exp_e));
      @(negedge clk);
   endtask

   initial begin
      exp_t e;
      logic [1:0] t;
      rst = 1'b0; req = 1'b0; mem_write = 1'b0; addr = '0; data_in = '0; u = 1'b0; mtype = 2'b00;
      rst_z = 1'b0; req_z = 1'b0; mem_write_z = 1'b0; addr_z = '0; data_in_z = '0; u_z = 1'b0;
      mtype_z = 2'b00;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready), 32'h1);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_data", data_out, 32'h0);
      rst = 1'b1; rst_z = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      for (int i = 0; i < (1 << (AW - 2)); i++) issue(1'b1, AW'(i * 4), $urandom, 1'b0, 2'b10);

      issue(1'b1, AW'(8),  32'hDEAD_BEEF, 1'b0, 2'b10);
      issue(1'b0, AW'(8),  32'h0,         1'b0, 2'b10);
      issue(1'b1, AW'(13), 32'h0000_0080, 1'b0, 2'b00);
      issue(1'b0, AW'(13), 32'h0,         1'b0, 2'b00);
      issue(1'b0, AW'(13), 32'h0,         1'b1, 2'b00);
      issue(1'b0, AW'(12), 32'h0,         1'b0, 2'b10);
      issue(1'b1, AW'(6),  32'h0000_8001, 1'b0, 2'b01);
      issue(1'b0, AW'(6),  32'h0,         1'b0, 2'b01);
      issue(1'b0, AW'(6),  32'h0,         1'b1, 2'b01);
      issue(1'b0, AW'(5),  32'h0,         1'b0, 2'b01);
      issue(1'b1, AW'(2),  32'h1234_5678, 1'b0, 2'b10);
      issue(1'b0, AW'(0),  32'h0,         1'b0, 2'b10);
      issue(1'b1, AW'(20), 32'hFFFF_FFFF, 1'b0, 2'b11);
      issue(1'b0, AW'(20), 32'h0,         1'b0, 2'b11);
      issue(1'b0, AW'(20), 32'h0,         1'b0, 2'b10);

      burst(40);
      drain();

      for (int i = 0; i < 200; i++) begin
         t = 2'($urandom);
         issue(1'($urandom), rand_addr(t), $urandom, 1'($urandom), t);
      end
      drain();

      // Abort a store in BUSY; memory must keep its old word.
      @(negedge clk);
      mem_write = 1'b1; addr = AW'(40); data_in = ~{ref_mem[43], ref_mem[42], ref_mem[41], ref_mem[40]};
      mtype = 2'b10; u = 1'b0; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      rst = 1'b0;
      #1;
      check("abort_ready", 32'(ready), 32'h1);
      check("abort_done", 32'(done), 32'h0);
      check("abort_err", 32'(err), 32'h0);
      check("abort_data", data_out, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      issue(1'b0, AW'(40), 32'h0, 1'b0, 2'b10);
      drain();

      op_z("z_st", 1'b1, AW'(16), 32'hCAFE_F00D, 1'b0, 2'b10, 32'h0, 1'b0);
      op_z("z_ld", 1'b0, AW'(16), 32'h0, 1'b0, 2'b10, 32'hCAFE_F00D, 1'b0);
      op_z("z_hmis", 1'b0, AW'(17), 32'h0, 1'b0, 2'b01, 32'h0, 1'b1);
      mem_write_z = 1'b1; addr_z = AW'(16); data_in_z = 32'h1111_1111; mtype_z = 2'b10; req_z = 1'b1;
      @(negedge clk);
      req_z = 1'b0;
      rst_z = 1'b0;
      #1;
      check("z_abort_ready", 32'(ready_z), 32'h1);
      check("z_abort_done", 32'(done_z), 32'h0);
      check("z_abort_err", 32'(err_z), 32'h0);
      check("z_abort_data", data_out_z, 32'h0);
      @(negedge clk);
      rst_z = 1'b1;
      @(negedge clk);
      op_z("z_ld2", 1'b0, AW'(16), 32'h0, 1'b1, 2'b01, 32'h0000_F00D, 1'b0);
      op_z("z_ld3", 1'b0, AW'(19), 32'h0, 1'b0, 2'b00, 32'hFFFF_FFCA, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
